// File: rtl/pio_sm_core.sv
// pio_sm_core: PIO state-machine execution core (JMP/WAIT/MOV/SET, delay, clock divider, wrap).
// IN/OUT/PUSH/PULL/IRQ retire as timed no-ops until the FIFO/shift blocks exist.
module pio_sm_core #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int NPINS  = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sm_en,
   input  logic [DIV_W-1:0]  clkdiv_int,
   input  logic [ADDR_W-1:0] wrap_top,
   input  logic [ADDR_W-1:0] wrap_bottom,
   input  logic [15:0]       instruction,
   output logic [ADDR_W-1:0] pc,
   input  logic [NPINS-1:0]  pins_in,
   input  logic              jmp_pin,
   input  logic              osr_empty,
   output logic [NPINS-1:0]  pins_out,
   output logic [NPINS-1:0]  pins_oe,
   output logic [DATA_W-1:0] x_out,
   output logic [DATA_W-1:0] y_out,
   output logic              stalled,
   output logic              exec_tick
);
   localparam int SW = NPINS < 5 ? NPINS : 5;
   logic [DIV_W-1:0]  div_cnt;
   logic [4:0]        delay_cnt;
   logic [DATA_W-1:0] x, y, src_val, rev_val, mov_val;
   logic [ADDR_W-1:0] pc_adv;
   logic [31:0]       pins_ext;
   logic [7:0]        jmp_conds;
   logic [2:0]        opc, arg;
   logic              tick, jmp_take, wait_ok;

   assign tick      = sm_en && (clkdiv_int <= DIV_W'(1) || div_cnt >= clkdiv_int - DIV_W'(1));
   assign exec_tick = tick;
   assign opc       = instruction[15:13];
   assign arg       = instruction[7:5];
   assign pc_adv    = (pc == wrap_top) ? wrap_bottom : pc + ADDR_W'(1);
   assign jmp_conds = {~osr_empty, jmp_pin, x != y, y != '0, y == '0, x != '0, x == '0, 1'b1};
   assign jmp_take  = jmp_conds[arg];
   // pins beyond NPINS read as zero through the zero-extended view
   assign pins_ext  = 32'(pins_in);
   assign wait_ok   = instruction[6] | (pins_ext[instruction[4:0]] == instruction[7]);
   assign src_val   = instruction[2:0] == 3'd0 ? DATA_W'(pins_in) :
                      instruction[2:0] == 3'd1 ? x :
                      instruction[2:0] == 3'd2 ? y : '0;
   for (genvar g = 0; g < DATA_W; g++) begin : g_rev
      assign rev_val[g] = src_val[DATA_W-1-g];
   end
   assign mov_val   = instruction[4:3] == 2'b01 ? ~src_val :
                      instruction[4:3] == 2'b10 ? rev_val : src_val;
   assign x_out     = x;
   assign y_out     = y;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= '0;
         x         <= '0;
         y         <= '0;
         pins_out  <= '0;
         pins_oe   <= '0;
         delay_cnt <= '0;
         div_cnt   <= '0;
         stalled   <= 1'b0;
      end else if (!sm_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick && delay_cnt != 5'd0) begin
            delay_cnt <= delay_cnt - 5'd1;
            stalled   <= 1'b0;
         end else if (tick) begin
            stalled   <= 1'b0;
            delay_cnt <= instruction[12:8];
            pc        <= pc_adv;
            case (opc)
               3'b000: begin
                  if (arg == 3'b010) x <= x - DATA_W'(1);
                  if (arg == 3'b100) y <= y - DATA_W'(1);
                  if (jmp_take) pc <= instruction[ADDR_W-1:0];
               end
               3'b001: if (!wait_ok) begin
                  stalled   <= 1'b1;
                  pc        <= pc;
                  delay_cnt <= '0;
               end
               3'b111: case (arg)
                  3'b000:  pins_out[SW-1:0] <= instruction[SW-1:0];
                  3'b001:  x <= DATA_W'(instruction[4:0]);
                  3'b010:  y <= DATA_W'(instruction[4:0]);
                  3'b100:  pins_oe[SW-1:0] <= instruction[SW-1:0];
                  default: ;
               endcase
               3'b101: case (arg)
                  3'b000:  pins_out <= mov_val[NPINS-1:0];
                  3'b001:  x <= mov_val;
                  3'b010:  y <= mov_val;
                  3'b101:  pc <= mov_val[ADDR_W-1:0];
                  default: ;
               endcase
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/pio_sm_core.md
Name: pio_sm_core

Overview:
Parametrised PIO state-machine execution core: fetches from instruction memory via pc and executes JMP (all conditions), WAIT (pin/gpio, stalling), MOV, SET and delay cycles, with an integer clock divider and program wrap. It supersedes the single-width JMP/SET sequencer. It drives NPINS output/enable pins and exposes scratch registers for debug. IN/OUT/PUSH/PULL/IRQ execute as timed no-ops until the FIFO/shift blocks land.

Parameters:
ADDR_W, 5, instruction-memory address width (1..5); jump target = instruction[ADDR_W-1:0]
DATA_W, 32, scratch register width (X, Y)
NPINS, 8, number of mapped pins (1..32)
DIV_W, 16, clock divider integer width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
sm_en  input  1  state machine enable; low freezes all state
clkdiv_int  input  DIV_W  execute one step every clkdiv_int cycles (0 and 1 = every cycle)
wrap_top  input  ADDR_W  last address of program loop
wrap_bottom  input  ADDR_W  loop restart address
instruction  input  16  instruction at pc (async-read memory, same cycle)
pc  output  ADDR_W  program counter
pins_in  input  NPINS  pin input values
jmp_pin  input  1  JMP PIN condition source
osr_empty  input  1  JMP !OSRE condition source (OSR empty)
pins_out  output  NPINS  pin output values
pins_oe  output  NPINS  pin output enables
x_out  output  DATA_W  X register
y_out  output  DATA_W  Y register
stalled  output  1  WAIT condition unsatisfied this tick
exec_tick  output  1  pulses on cycles where the core steps

Behaviour:
- Reset (clk edge with rst=1): pc, x, y, pins_out, pins_oe, delay counter, divider counter, stalled <= 0; rst dominates sm_en.
- Divider: counter cleared while sm_en=0. With sm_en=1, tick when counter >= clkdiv_int-1 (clkdiv_int<=1: every cycle), then counter <= 0, else counter+1. exec_tick = tick (combinational).
- Per tick: if delay_cnt != 0: delay_cnt--, nothing else. Else execute instruction; on completion delay_cnt <= instruction[12:8] (full 5-bit delay, no side-set).
- Advance: pc <= (pc == wrap_top) ? wrap_bottom : pc+1 (mod 2^ADDR_W). Taken jump overrides wrap.
- JMP (000): cond [7:5]: 000 always; 001 X==0; 010 X!=0 then X<=X-1 (decrement whether taken or not, wraps 0->all ones); 011 Y==0; 100 Y!=0 then Y--; 101 X!=Y; 110 jmp_pin==1; 111 osr_empty==0. Condition uses pre-decrement value. Taken: pc <= instruction[ADDR_W-1:0].
- WAIT (001): pol=[7], src=[6:5], idx=[4:0]. src 00/01: condition pins_in[idx]==pol (idx>=NPINS reads 0); src 10/11 (IRQ/reserved): always satisfied. Unsatisfied: stalled=1, pc held, no delay loaded, re-evaluated every tick. Satisfied: stalled=0, advance, load delay.
- SET (111): dst [7:5]: 000 pins_out[min(NPINS,5)-1:0] <= data; 001 X <= zero-ext data; 010 Y <= zero-ext; 100 pins_oe low bits <= data; others no-op. Advance.
- MOV (101): dst [7:5], op [4:3], src [2:0]. src: 000 pins_in zero-ext, 001 X, 010 Y, 011 zero, others zero. op: 00 none, 01 bitwise invert, 10 bit-reverse (over DATA_W), 11 none. dst: 000 pins_out <= value[NPINS-1:0]; 001 X; 010 Y; 101 pc <= value[ADDR_W-1:0] (delay still loaded); others no-op. MOV X,X / Y,Y legal.
- 010/011/100/110 (IN/OUT/PUSH/PULL/IRQ): no-op, advance, delay honoured.
- sm_en=0 mid-delay or mid-stall: state frozen, resumes exactly on re-enable. rst mid-delay/stall: clears per reset list.
- wrap_top/wrap_bottom may change any cycle; sampled at each advance.

Test Plan:
- Reset then SET X,5 (0xE025) at pc0 -> x_out=5, pc=1 after one tick; rst next cycle -> x_out=0, pc=0.
- X=3, JMP X--,0 at pc2 looped -> taken 3 times (X 3->2->1->0), 4th falls through to pc3 with X=0xFFFFFFFF.
- wrap_top=4, wrap_bottom=1, NOPs -> pc sequence 0,1,2,3,4,1,2; JMP 7 at pc4 -> pc=7 (no wrap).
- WAIT 1 GPIO 3 with pins_in[3]=0 for 5 cycles -> stalled=1, pc held; pins_in[3]=1 -> pc advances next tick, stalled=0.
- clkdiv_int=3, SET instruction with delay 2 -> exec_tick every 3rd cycle; next instruction executes 3 ticks (9 cycles) later.
- MOV Y,~X with X=0x0000000F -> y_out=0xFFFFFFF0; MOV X,::Y -> x_out=0x0FFFFFFF; MOV PINS,X with NPINS=8 -> pins_out=0xFF.
